// File: rtl/mem_ctrl.sv
// MEM-stage memory access controller: drives a single-outstanding bus, stalls the
// pipeline during the access and formats load / LL / SC results for MEM/WB.
module mem_ctrl #(
  localparam int unsigned DW  = 32,
  localparam int unsigned AW  = 32,
  localparam int unsigned RW  = 5,
  localparam int unsigned OPW = 4,
  localparam int unsigned SLW = 4
) (
  input  logic           clk,
  input  logic           rst,

  input  logic [RW-1:0]  in_dest_addr,
  input  logic           in_wreg,
  input  logic [DW-1:0]  in_dest_data,
  input  logic [DW-1:0]  in_hi,
  input  logic [DW-1:0]  in_lo,
  input  logic           in_whilo,

  input  logic [OPW-1:0] in_mem_op,
  input  logic [AW-1:0]  in_mem_addr,
  input  logic [DW-1:0]  in_store_data,

  input  logic           llbit_in,

  output logic           bus_req,
  output logic           bus_we,
  output logic [AW-1:0]  bus_addr,
  output logic [SLW-1:0] bus_sel,
  output logic [DW-1:0]  bus_wdata,
  input  logic [DW-1:0]  bus_rdata,
  input  logic           bus_ack,

  output logic [RW-1:0]  mem_dest_addr,
  output logic           mem_wreg,
  output logic [DW-1:0]  mem_dest_data,
  output logic [DW-1:0]  mem_hi,
  output logic [DW-1:0]  mem_lo,
  output logic           mem_whilo,
  output logic           mem_llbit_we,
  output logic           mem_llbit_data,

  output logic           stallreq,
  output logic           misalign
);

  localparam logic [OPW-1:0] OP_LB  = 4'd1;
  localparam logic [OPW-1:0] OP_LBU = 4'd2;
  localparam logic [OPW-1:0] OP_LH  = 4'd3;
  localparam logic [OPW-1:0] OP_LHU = 4'd4;
  localparam logic [OPW-1:0] OP_LW  = 4'd5;
  localparam logic [OPW-1:0] OP_SB  = 4'd6;
  localparam logic [OPW-1:0] OP_SH  = 4'd7;
  localparam logic [OPW-1:0] OP_SW  = 4'd8;
  localparam logic [OPW-1:0] OP_LL  = 4'd9;
  localparam logic [OPW-1:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_rdata_q;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_sc;
  logic            w_is_ll;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_misalign;
  logic            w_need;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_load_data;

  // Operation decode; unused encodings fall through as no memory op
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_sc    = 1'b0;
    w_is_ll    = 1'b0;
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    case (in_mem_op)
      OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
      OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
      OP_LW:         begin w_is_load  = 1'b1; w_is_word = 1'b1; end
      OP_LL:         begin w_is_load  = 1'b1; w_is_word = 1'b1; w_is_ll = 1'b1; end
      OP_SB:         begin w_is_store = 1'b1; w_is_byte = 1'b1; end
      OP_SH:         begin w_is_store = 1'b1; w_is_half = 1'b1; end
      OP_SW:         begin w_is_store = 1'b1; w_is_word = 1'b1; end
      OP_SC:         begin w_is_sc    = 1'b1; w_is_word = 1'b1; end
      default:       ;
    endcase
  end

  // Alignment is evaluated before llbit_in so a misaligned SC always faults
  assign w_misalign = (w_is_half & in_mem_addr[0]) |
                      (w_is_word & (in_mem_addr[1:0] != 2'b00));
  assign w_need     = (w_is_load | w_is_store | (w_is_sc & llbit_in)) & ~w_misalign;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_need)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (bus_ack) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read data is held so the result survives bus_rdata changing after ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_rdata_q <= '0;
    else if (r_state == ST_BUSY && bus_ack)  r_rdata_q <= bus_rdata;
  end

  // Big-endian lane extraction: offset 0 is the most significant byte
  always_comb begin
    w_byte = r_rdata_q[31:24];
    case (in_mem_addr[1:0])
      2'd0: w_byte = r_rdata_q[31:24];
      2'd1: w_byte = r_rdata_q[23:16];
      2'd2: w_byte = r_rdata_q[15:8];
      2'd3: w_byte = r_rdata_q[7:0];
      default: w_byte = r_rdata_q[31:24];
    endcase
    w_half = in_mem_addr[1] ? r_rdata_q[15:0] : r_rdata_q[31:16];
  end

  always_comb begin
    w_load_data = r_rdata_q;
    case (in_mem_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = r_rdata_q;
    endcase
  end

  // Bus-side outputs
  always_comb begin
    bus_req   = (r_state == ST_BUSY) & ~rst;
    bus_we    = w_is_store | w_is_sc;
    bus_addr  = {in_mem_addr[31:2], 2'b00};
    bus_sel   = 4'b0000;
    bus_wdata = in_store_data;
    if (w_is_load) begin
      bus_sel = 4'b1111;
    end else if (w_is_byte) begin
      bus_wdata = {4{in_store_data[7:0]}};
      case (in_mem_addr[1:0])
        2'd0: bus_sel = 4'b1000;
        2'd1: bus_sel = 4'b0100;
        2'd2: bus_sel = 4'b0010;
        2'd3: bus_sel = 4'b0001;
        default: bus_sel = 4'b0000;
      endcase
    end else if (w_is_half) begin
      bus_wdata = {2{in_store_data[15:0]}};
      bus_sel   = in_mem_addr[1] ? 4'b0011 : 4'b1100;
    end else if (w_is_word) begin
      bus_sel = 4'b1111;
    end
  end

  // Pipeline-side outputs; results only released in DONE for real accesses
  always_comb begin
    stallreq       = ~rst & (((r_state == ST_IDLE) & w_need) | (r_state == ST_BUSY));
    misalign       = w_misalign;
    mem_dest_addr  = in_dest_addr;
    mem_hi         = in_hi;
    mem_lo         = in_lo;
    mem_whilo      = in_whilo;
    mem_wreg       = in_wreg;
    mem_dest_data  = in_dest_data;
    mem_llbit_we   = 1'b0;
    mem_llbit_data = 1'b0;
    if (w_misalign) begin
      mem_wreg = 1'b0;
    end else if (w_need) begin
      mem_wreg = 1'b0;
      if (r_state == ST_DONE) begin
        mem_wreg = in_wreg;
        if (w_is_load) mem_dest_data = w_load_data;
        if (w_is_ll) begin
          mem_llbit_we   = 1'b1;
          mem_llbit_data = 1'b1;
        end
        if (w_is_sc) begin
          mem_dest_data  = 32'd1;
          mem_llbit_we   = 1'b1;
          mem_llbit_data = 1'b0;
        end
      end
    end else if (w_is_sc) begin
      mem_dest_data = '0;
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: in_dest_addr in 5, in_wreg in 1, in_dest_data in 32, in_hi in 32, in_lo in 32, in_whilo in 1: EX/MEM register outputs.
REQ-003 SHALL have ports: in_mem_op in 4 (0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as none), in_mem_addr in 32, in_store_data in 32.
REQ-004 SHALL have port llbit_in  in  1: current LLbit, already forwarded externally.
REQ-005 SHALL have bus ports: bus_req out 1, bus_we out 1, bus_addr out 32, bus_sel out 4, bus_wdata out 32, bus_rdata in 32, bus_ack in 1.
REQ-006 SHALL have outputs to MEM/WB: mem_dest_addr 5, mem_wreg 1, mem_dest_data 32, mem_hi 32, mem_lo 32, mem_whilo 1, mem_llbit_we 1, mem_llbit_data 1.
REQ-007 SHALL have outputs stallreq 1 (pipeline stall request) and misalign 1 (address-error flag).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE; rdata holding register rdata_q (32b).
REQ-009 IDLE: access needed (load, store, LL, or SC with llbit_in=1) and aligned -> BUSY next edge; else stay IDLE.
REQ-010 BUSY: bus_ack=1 -> capture bus_rdata into rdata_q, -> DONE; bus_ack=0 -> stay BUSY, no timeout.
REQ-011 DONE: -> IDLE unconditionally next edge.
REQ-012 bus_req SHALL be 1 only in BUSY; bus_addr={in_mem_addr[31:2],2'b00}; bus_we=1 for SB/SH/SW/SC.
REQ-013 Byte lanes big-endian: byte offset 0 -> bus_sel 1000 (bits 31:24), offset 3 -> 0001; half offset 0 -> 1100, offset 2 -> 0011; word -> 1111; bus_sel=1111 for all loads.
REQ-014 bus_wdata: SB replicates in_store_data[7:0] x4; SH replicates [15:0] x2; SW/SC pass [31:0].
REQ-015 stallreq SHALL be 1 in IDLE when an access is needed and aligned, and throughout BUSY; 0 in DONE and otherwise.
REQ-016 Pass-through (all states): mem_dest_addr, mem_hi, mem_lo, mem_whilo equal their in_* inputs.
REQ-017 Non-memory op: mem_wreg=in_wreg, mem_dest_data=in_dest_data, llbit outputs 0.
REQ-018 Loads: mem_dest_data formed from rdata_q in DONE; LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW/LL full word; mem_wreg=in_wreg.
REQ-019 LL: in DONE mem_llbit_we=1, mem_llbit_data=1.
REQ-020 SC with llbit_in=0: no bus access, no stall, mem_dest_data=0, mem_wreg=in_wreg, mem_llbit_we=0.
REQ-021 SC with llbit_in=1: store via bus; in DONE mem_dest_data=1, mem_llbit_we=1, mem_llbit_data=0.
REQ-022 mem_wreg and mem_llbit_we SHALL be 0 in IDLE/BUSY while an access is pending (no partial results leak).
REQ-023 Misaligned (LH/LHU/SH addr[0]=1; LW/SW/LL/SC addr[1:0]!=0): misalign=1, no bus access, no stall, mem_wreg=0, mem_llbit_we=0.
REQ-024 SC misaligned check SHALL take priority over llbit_in.
REQ-025 Load latency: result valid in DONE, minimum 3 cycles from op presentation (IDLE, BUSY with ack, DONE).
REQ-026 Inputs SHALL be held stable by the pipeline while stallreq=1; block does not register them.

Reset
REQ-027 rst=1 SHALL force state IDLE, rdata_q=0 immediately, independent of clk.
REQ-028 During reset: bus_req=0, stallreq=0, mem_llbit_we=0; reset mid-BUSY abandons the transaction with bus_req deasserted the same cycle.

Verification
REQ-029 LB addr 0x103, rdata 0x112233F4, ack after 2 BUSY cycles -> bus_sel 1111, stallreq 1 for 3 cycles, DONE data 0xFFFFFFF4.
REQ-030 SH addr 0x102, store_data 0x0000ABCD, ack immediate -> bus_we 1, bus_sel 0011, bus_wdata 0xABCDABCD, bus_addr 0x100.
REQ-031 LW addr 0x101 -> misalign 1, bus_req 0, stallreq 0, mem_wreg 0.
REQ-032 SC llbit_in=0 -> no bus_req, mem_dest_data 0; SC llbit_in=1 -> store, DONE data 1, llbit_we 1, llbit_data 0.
REQ-033 LL addr 0x200, rdata 0xDEADBEEF -> DONE data 0xDEADBEEF, llbit_we 1, llbit_data 1.
REQ-034 rst pulsed mid-BUSY -> bus_req 0 and stallreq 0 before next clk edge; state IDLE after release.
